// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_pkg: shared width, funct3 encodings and FSM state type
// for the M-stage data-memory controller.
package dmem_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      DRAIN
   } state_t;

   // Access size lives in funct3[1:0]; halves need even, words need 4-aligned.
   function automatic logic misaligned_f(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      unique case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: pipeline-side and memory-side signals of the
// data-memory controller; slave = controller view, master = environment.
interface dmem_access_ctrl_if;
   import dmem_pkg::*;

   logic            m_rd;
   logic            m_wr;
   logic [2:0]      m_funct3;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic            waiting;
   logic [XLEN-1:0] ld_data;
   logic            misaligned;
   logic            mem_req;
   logic            mem_we;
   logic [XLEN-1:0] mem_addr;
   logic [3:0]      mem_wstrb;
   logic [XLEN-1:0] mem_wdata;
   logic            mem_ack;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  m_rd, m_wr, m_funct3, m_addr, m_wdata,
      input  mem_ack, mem_rdata,
      output waiting, ld_data, misaligned,
      output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );

   modport master (
      output m_rd, m_wr, m_funct3, m_addr, m_wdata,
      output mem_ack, mem_rdata,
      input  waiting, ld_data, misaligned,
      input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
   );

endinterface

// File: rtl/dmem_access_ctrl_load_align.sv
// load_align: picks the addressed byte/half of a memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
   import dmem_pkg::*;
(
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_off,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_b;
   logic [15:0] w_h;

   always_comb begin
      w_b = i_rdata[7:0];
      unique case (i_off)
         2'd0: w_b = i_rdata[7:0];
         2'd1: w_b = i_rdata[15:8];
         2'd2: w_b = i_rdata[23:16];
         2'd3: w_b = i_rdata[31:24];
      endcase
      w_h = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = i_rdata;
      unique case (i_funct3)
         F3_LB:   o_data = {{24{w_b[7]}}, w_b};
         F3_LH:   o_data = {{16{w_h[15]}}, w_h};
         F3_LBU:  o_data = {24'd0, w_b};
         F3_LHU:  o_data = {16'd0, w_h};
         F3_LW:   o_data = i_rdata;
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: M-stage load/store controller, req/ack memory handshake, pipeline stall.
// Define STORE_BUFFER_EN for a one-entry background store buffer (DRAIN state).
module dmem_access_ctrl
   import dmem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   dmem_access_ctrl_if.slave bus
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_mem_req;
   logic            r_mem_we;
   logic [XLEN-1:0] r_mem_addr;
   logic [3:0]      r_mem_wstrb;
   logic [XLEN-1:0] r_mem_wdata;
   logic [XLEN-1:0] r_ld_data;
   logic [2:0]      r_f3;
   logic [1:0]      r_off;

   logic            w_any;
   logic            w_is_st;
   logic            w_mis;
   logic            w_access;
   logic            w_ack;
   logic            w_launch;
   logic            w_waiting;
   logic [3:0]      w_strb;
   logic [XLEN-1:0] w_lane;
   logic [XLEN-1:0] w_fmt;

   // A simultaneous rd/wr is a load; the store half is dropped.
   assign w_any    = bus.m_rd | bus.m_wr;
   assign w_is_st  = bus.m_wr & ~bus.m_rd;
   assign w_mis    = misaligned_f(bus.m_funct3, bus.m_addr[1:0]);
   assign w_access = w_any & ~w_mis;
   assign w_ack    = r_mem_req & bus.mem_ack;

   always_comb begin
      w_strb = 4'b1111;
      w_lane = bus.m_wdata;
      unique case (1'b1)
         (bus.m_funct3[1:0] == F3_SB[1:0]): begin
            w_strb = 4'b0001 << bus.m_addr[1:0];
            w_lane = {4{bus.m_wdata[7:0]}};
         end
         (bus.m_funct3[1:0] == F3_SH[1:0]): begin
            w_strb = 4'b0011 << bus.m_addr[1:0];
            w_lane = {2{bus.m_wdata[15:0]}};
         end
         (bus.m_funct3[1:0] == F3_SW[1:0]): begin
            w_strb = 4'b1111;
            w_lane = bus.m_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_waiting   = 1'b0;
      w_launch    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_access) begin
               w_launch    = 1'b1;
               w_waiting   = 1'b1;
               w_state_nxt = BUSY;
`ifdef STORE_BUFFER_EN
               if (w_is_st) begin
                  w_waiting   = 1'b0;
                  w_state_nxt = DRAIN;
               end
`endif
            end
         end
         BUSY: begin
            w_waiting = 1'b1;
            if (w_ack) w_state_nxt = DONE;
         end
         DONE: w_state_nxt = IDLE;
`ifdef STORE_BUFFER_EN
         // Anything new waits for the buffered store to retire.
         DRAIN: begin
            w_waiting = w_any;
            if (w_ack) w_state_nxt = IDLE;
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wstrb <= 4'b0000;
         r_mem_wdata <= '0;
         r_ld_data   <= '0;
         r_f3        <= 3'b000;
         r_off       <= 2'b00;
      end else if (w_launch) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= w_is_st;
         r_mem_addr  <= {bus.m_addr[XLEN-1:2], 2'b00};
         r_mem_wstrb <= w_is_st ? w_strb : 4'b0000;
         r_mem_wdata <= w_is_st ? w_lane : '0;
         r_f3        <= bus.m_funct3;
         r_off       <= bus.m_addr[1:0];
      end else if (w_ack) begin
         r_mem_req <= 1'b0;
         if (!r_mem_we) r_ld_data <= w_fmt;
      end
   end

   load_align u_align (
      .i_rdata  (bus.mem_rdata),
      .i_off    (r_off),
      .i_funct3 (r_f3),
      .o_data   (w_fmt)
   );

   assign bus.waiting    = w_waiting & ~rst;
   assign bus.misaligned = (r_state == IDLE) & w_any & w_mis & ~rst;
   assign bus.ld_data    = r_ld_data;
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wstrb  = r_mem_wstrb;
   assign bus.mem_wdata  = r_mem_wdata;

endmodule
